// File: rtl/tiny_canvas_pkg.sv
// Shared types and constants for the tiny canvas pixel path.
package tiny_canvas_pkg;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pixel_t;

  localparam int PIXQ_DEPTH = 16;
  localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/pixel_queue_mem.sv
// Pixel storage for pixel_queue: synchronous write, asynchronous read, no reset.
module pixel_queue_mem
  import tiny_canvas_pkg::*;
#(
  parameter int DEPTH  = PIXQ_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  pixel_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output pixel_t            rdata
);

  pixel_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_queue.sv
// First-word-fall-through pixel queue with consecutive-duplicate filtering,
// sticky overflow flag and saturating drop counter.
module pixel_queue
  import tiny_canvas_pkg::*;
#(
  parameter int DEPTH  = PIXQ_DEPTH,
  parameter int ADDR_W = 4,
  parameter int DEDUP  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic [7:0]      x_in,
  input  logic [7:0]      y_in,
  input  logic [2:0]      c_in,
  input  logic            pop,
  output logic [7:0]      x_out,
  output logic [7:0]      y_out,
  output logic [2:0]      c_out,
  output logic            out_valid,
  output logic            full,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  output logic [7:0]      drop_cnt
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  pixel_t            last_pix;
  logic              last_valid;
  pixel_t            in_pix;
  pixel_t            head_pix;
  pixel_t            head_sel;
  logic              is_dup;
  logic              pop_eff;
  logic              accept;
  logic              drop;

  assign in_pix    = {x_in, y_in, c_in};
  assign out_valid = (cnt != '0);
  assign full      = (cnt == FULL_COUNT);
  assign count     = cnt;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign is_dup  = (DEDUP != 0) && last_valid && (in_pix == last_pix);
  assign pop_eff = pop && out_valid;
  assign accept  = push && !is_dup && (!full || pop_eff);
  assign drop    = push && !is_dup && !accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      last_pix   <= '0;
      last_valid <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      last_valid <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (accept) begin
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        last_pix   <= in_pix;
        last_valid <= 1'b1;
      end
      if (pop_eff) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({accept, pop_eff})
        2'b10:   cnt <= cnt + (ADDR_W + 1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W + 1)'(1);
        default: cnt <= cnt;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  pixel_queue_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (accept && !clear),
    .waddr (wr_ptr),
    .wdata (in_pix),
    .raddr (rd_ptr),
    .rdata (head_pix)
  );

  assign head_sel = out_valid ? head_pix : '0;
  assign x_out    = head_sel.x;
  assign y_out    = head_sel.y;
  assign c_out    = head_sel.c;

endmodule

// File: tb/tb_pixel_queue.sv
// Scoreboard bench for pixel_queue: a reference queue model predicts every head and status output.
module tb_pixel_queue;
  import tiny_canvas_pkg::*;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       push;
  logic       pop;
  pixel_t     pix_in;
  logic [7:0] x_out, y_out;
  logic [2:0] c_out;
  logic       out_valid, full, overflow;
  logic [4:0] count;
  logic [7:0] drop_cnt;

  logic       b_en;
  logic [7:0] xb_out, yb_out;
  logic [2:0] cb_out;
  logic       b_valid, b_full, b_overflow;
  logic [4:0] b_count;
  logic [7:0] b_drop;

  pixel_t     model_q[$];
  pixel_t     model_last;
  bit         model_last_valid;
  bit         model_ovf;
  int         model_drop;
  int         errors = 0;
  int         checks = 0;

  pixel_queue #(.DEPTH(16), .ADDR_W(4), .DEDUP(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push),
    .x_in(pix_in.x), .y_in(pix_in.y), .c_in(pix_in.c), .pop(pop),
    .x_out(x_out), .y_out(y_out), .c_out(c_out), .out_valid(out_valid),
    .full(full), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  pixel_queue #(.DEPTH(16), .ADDR_W(4), .DEDUP(0)) dut_nodedup (
    .clk(clk), .rst(rst), .clear(clear), .push(push && b_en),
    .x_in(pix_in.x), .y_in(pix_in.y), .c_in(pix_in.c), .pop(1'b0),
    .x_out(xb_out), .y_out(yb_out), .c_out(cb_out), .out_valid(b_valid),
    .full(b_full), .count(b_count), .overflow(b_overflow), .drop_cnt(b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pixel_t mkPix(input int x, input int y, input int c);
    pixel_t p;
    p.x = 8'(x);
    p.y = 8'(y);
    p.c = 3'(c);
    return p;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    pixel_t head;
    head = (model_q.size() > 0) ? model_q[0] : '0;
    checkVal("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    checkVal("full", 32'(full), 32'(model_q.size() == 16));
    checkVal("count", 32'(count), 32'(model_q.size()));
    checkVal("overflow", 32'(overflow), 32'(model_ovf));
    checkVal("drop_cnt", 32'(drop_cnt), 32'(model_drop));
    checkVal("head_x", 32'(x_out), 32'(head.x));
    checkVal("head_y", 32'(y_out), 32'(head.y));
    checkVal("head_c", 32'(c_out), 32'(head.c));
  endtask

  task automatic modelReset();
    model_q.delete();
    model_last_valid = 1'b0;
    model_ovf        = 1'b0;
    model_drop       = 0;
  endtask

  // Checks the current outputs, drives one cycle of stimulus and advances the model.
  task automatic applyStimulus(input bit p, input pixel_t px, input bit po, input bit cl);
    bit pop_eff, dup, acc;
    @(negedge clk);
    checkOutput();
    push   = p;
    pix_in = px;
    pop    = po;
    clear  = cl;
    if (cl) begin
      modelReset();
    end else begin
      pop_eff = po && (model_q.size() > 0);
      dup     = model_last_valid && (px == model_last);
      acc     = p && !dup && ((model_q.size() < 16) || pop_eff);
      if (pop_eff) void'(model_q.pop_front());
      if (acc) begin
        model_q.push_back(px);
        model_last       = px;
        model_last_valid = 1'b1;
      end
      if (p && !dup && !acc) begin
        model_ovf = 1'b1;
        if (model_drop < 255) model_drop++;
      end
    end
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    pixel_t last_burst;
    rst    = 1'b1;
    clear  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    b_en   = 1'b0;
    pix_in = '0;
    modelReset();
    #12;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    // Single push then pop
    applyStimulus(1, mkPix(10, 20, 5), 0, 0);
    @(negedge clk);
    checkVal("first_valid", 32'(out_valid), 32'd1);
    checkVal("first_x", 32'(x_out), 32'd10);
    checkVal("first_y", 32'(y_out), 32'd20);
    checkVal("first_c", 32'(c_out), 32'd5);
    checkVal("first_count", 32'(count), 32'd1);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 0, 0);

    // Fill, overflow, full push+pop, drain in order
    for (int i = 0; i < 16; i++) applyStimulus(1, mkPix(i + 30, i + 100, i % 8), 0, 0);
    applyStimulus(1, mkPix(1, 1, 1), 0, 0);
    @(negedge clk);
    checkVal("ovf_full", 32'(full), 32'd1);
    checkVal("ovf_flag", 32'(overflow), 32'd1);
    checkVal("ovf_drop", 32'(drop_cnt), 32'd1);
    applyStimulus(1, mkPix(200, 200, 7), 1, 0);
    @(negedge clk);
    checkVal("fullpp_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 0, 0);

    // Duplicate filter, with the DEDUP=0 instance seeing the same pushes
    applyStimulus(0, '0, 0, 1);
    b_en = 1'b1;
    applyStimulus(1, mkPix(5, 5, 2), 0, 0);
    applyStimulus(1, mkPix(5, 5, 2), 0, 0);
    applyStimulus(1, mkPix(5, 5, 2), 0, 0);
    applyStimulus(1, mkPix(5, 6, 2), 0, 0);
    b_en = 1'b0;
    @(negedge clk);
    checkVal("dedup_count", 32'(count), 32'd2);
    checkVal("nodedup_count", 32'(b_count), 32'd4);
    applyStimulus(0, '0, 0, 1);

    // Empty queue push+pop: pop ignored
    applyStimulus(1, mkPix(7, 8, 3), 1, 0);
    @(negedge clk);
    checkVal("emptypp_count", 32'(count), 32'd1);
    applyStimulus(0, '0, 0, 1);

    // Drop counter saturation, then clear beats push
    for (int i = 0; i < 16; i++) applyStimulus(1, mkPix(i, 50, 4), 0, 0);
    for (int i = 0; i < 300; i++) applyStimulus(1, mkPix(1, 1, 1), 0, 0);
    @(negedge clk);
    checkVal("sat_drop", 32'(drop_cnt), 32'd255);
    applyStimulus(1, mkPix(2, 2, 2), 0, 1);
    @(negedge clk);
    checkVal("clr_count", 32'(count), 32'd0);
    checkVal("clr_ovf", 32'(overflow), 32'd0);
    checkVal("clr_drop", 32'(drop_cnt), 32'd0);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) applyStimulus(1, mkPix(60 + i, 70, i), 0, 0);
    last_burst = mkPix(62, 70, 2);
    @(negedge clk);
    push   = 1'b1;
    pix_in = mkPix(63, 70, 3);
    #2;
    rst = 1'b1;
    #1;
    checkVal("rst_valid", 32'(out_valid), 32'd0);
    checkVal("rst_count", 32'(count), 32'd0);
    checkVal("rst_x", 32'(x_out), 32'd0);
    checkVal("rst_drop", 32'(drop_cnt), 32'd0);
    push = 1'b0;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, last_burst, 0, 0);
    @(negedge clk);
    checkVal("post_rst_count", 32'(count), 32'd1);
    applyStimulus(0, '0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_queue.md
# pixel_queue

Buffers pixel packets between `packet_generator` and `i2c_slave`, so bursts from brush expansion and symmetry do not overrun the I2C master's read rate. Each entry holds an (x, y, colour) triple. The queue is first-word-fall-through and filters back-to-back duplicate pixels. It reports occupancy, a sticky overflow flag and a saturating drop counter, which feed the status readout.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; must be a power of two, minimum 2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `DEDUP`, 1: 1 enables the consecutive-duplicate filter; 0 disables it.

Ports:
- `clk`  in  1: the single clock; all state is updated on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `clear`  in  1: synchronous flush of all queue state.
- `push`  in  1: pulse meaning a new pixel is available (`packet_generator` valid).
- `x_in`  in  8: pixel x.
- `y_in`  in  8: pixel y.
- `c_in`  in  3: pixel colour, {R,G,B}.
- `pop`  in  1: the I2C side has consumed the head entry.
- `x_out`  out  8: head entry x.
- `y_out`  out  8: head entry y.
- `c_out`  out  3: head entry colour.
- `out_valid`  out  1: queue is not empty.
- `full`  out  1: count equals `DEPTH`.
- `count`  out  `ADDR_W`+1: number of entries held.
- `overflow`  out  1: sticky flag, set when a push is dropped because the queue is full.
- `drop_cnt`  out  8: saturating count of pushes dropped because the queue is full.

## Operation
Pointers and count:
- `wr_ptr` and `rd_ptr` are `ADDR_W` bits wide and wrap modulo `DEPTH`.
- `count` is tracked explicitly and ranges from 0 to `DEPTH`.

Push:
- A push is a *duplicate* when all of the following hold: `DEDUP`=1, `last_valid`=1, and {x_in,y_in,c_in} equals the last accepted entry.
- A duplicate push is discarded silently. It does not set `overflow` or change `drop_cnt`.
- A push is *accepted* when it is not a duplicate and either `full`=0 or `pop`=1 with `out_valid`=1 in the same cycle.
- On acceptance: write the entry to the `wr_ptr` slot, increment `wr_ptr`, load `last_*` with the entry, and set `last_valid`.
- A push that is neither a duplicate nor accepted is dropped. `overflow` is set and `drop_cnt` increments, saturating at 255.

Pop:
- A pop is effective only when `out_valid`=1. It increments `rd_ptr`.
- A pop when empty is ignored, with no error.

Simultaneous events:
- Effective pop with accepted push: `count` is unchanged.
- Full queue with push and pop in the same cycle: the push is accepted and `count` stays at `DEPTH`.
- Empty queue with push and pop in the same cycle: the pop is ignored, the push is accepted, and `count` becomes 1.

Clear:
- `clear` has priority over push and pop in the same cycle.
- It zeroes the pointers, `count`, `last_valid`, `overflow` and `drop_cnt`.
- Storage contents are not cleared.

Head outputs:
- `x_out`, `y_out` and `c_out` are read combinationally from the `rd_ptr` slot.
- When `out_valid`=0 they are forced to 0.

## Timing
- Reset values: all pointers, `count`, `out_valid`, `full`, `overflow`, `last_valid` and `drop_cnt` are 0. Head outputs are 0.
- Push latency: push sampled at edge N → `out_valid`=1 and head data valid after edge N, i.e. readable in cycle N+1.
- Pop latency: pop sampled at edge N → the next entry, or `out_valid`=0, is presented after edge N.
- `full` and `out_valid` are decoded from registered `count`; there is no combinational path from `push` or `pop` to them.
- The only input-to-output combinational path is `rd_ptr` to the head data.
- Sustained throughput is 1 push and 1 pop per cycle.
- Reset asserted mid-burst: all state is lost immediately and asynchronously. The first push after reset deassertion is never treated as a duplicate.

## Structure
- Shared package `tiny_canvas_pkg`:
  - `pixel_t` packed struct {x[7:0], y[7:0], c[2:0]}, 19 bits.
  - `PIXQ_DEPTH` default constant.
  - `DROP_MAX`=8'hFF.
- One sub-module, `pixel_queue_mem`:
  - `DEPTH`×19 register array.
  - One synchronous write port.
  - One asynchronous read port.
  - No reset on the storage.
- Pointer, count, dedup and overflow logic live in the top `pixel_queue`.

## Test plan
- Reset, then push (10,20,3'b101) → next cycle `out_valid`=1, head=(10,20,5), `count`=1; pop → `out_valid`=0, head=0.
- Push 16 distinct pixels, then push (1,1,1) → `full`=1, `overflow`=1, `drop_cnt`=1; pop 16 times → original order preserved, and (1,1,1) never appears.
- With `full`=1, push and pop in the same cycle → `count` stays 16, the new pixel appears as the 16th entry after draining.
- `DEDUP`=1: push (5,5,2) three times, then (5,6,2) → `count`=2; with `DEDUP`=0 the same stimulus → `count`=4.
- Overflow stress: hold `full` and push 300 drops → `drop_cnt`=255 and saturated; assert `clear` together with push → `count`=0, `overflow`=0, `drop_cnt`=0, and the push is ignored.
- Assert `rst` mid-way through a 5-pixel burst → outputs 0 immediately; after release, re-pushing the last pre-reset pixel is accepted and `count`=1.
